// File: rtl/intt_butterfly_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | intt_butterfly_if : stream bus of the inverse GS butterfly (in/out) |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface intt_butterfly_if #(
  parameter int W = 16
);
  logic                in_valid;
  logic                in_ready;
  logic                mode_scale_i;
  logic signed [W-1:0] coeff_a_i;
  logic signed [W-1:0] coeff_b_i;
  logic signed [W-1:0] twiddle_i;
  logic                out_valid;
  logic                out_ready;
  logic        [W-1:0] coeff_a_o;
  logic        [W-1:0] coeff_b_o;

  modport master (
    output in_valid, mode_scale_i, coeff_a_i, coeff_b_i, twiddle_i, out_ready,
    input  in_ready, out_valid, coeff_a_o, coeff_b_o
  );

  modport slave (
    input  in_valid, mode_scale_i, coeff_a_i, coeff_b_i, twiddle_i, out_ready,
    output in_ready, out_valid, coeff_a_o, coeff_b_o
  );
endinterface
`default_nettype wire

// File: rtl/intt_butterfly.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | intt_butterfly : 3-stage Gentleman-Sande butterfly, mod Q, Montgomery|
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module intt_butterfly #(
  parameter int W    = 16,
  parameter int Q    = 3329,
  parameter int QINV = 62209
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  intt_butterfly_if.slave bus,
  output logic            busy_o
);
  localparam int                 WP1    = W + 1;
  localparam int                 W2     = 2 * W;
  localparam logic signed [W:0]  C_QE   = WP1'(Q);
  localparam logic signed [W2-1:0] C_QW = W2'(Q);
  localparam logic [W-1:0]       C_QINV = W'(QINV);

  // Single conditional correction brings [-Q,2Q) into [0,Q).
  function automatic logic signed [W:0] reduce_in(input logic signed [W-1:0] x);
    logic signed [W:0] v;
    v = {x[W-1], x};
    if (v < 0)          v = v + C_QE;
    else if (v >= C_QE) v = v - C_QE;
    return v;
  endfunction

  function automatic logic [W-1:0] mont(input logic signed [W2-1:0] t);
    logic        [W-1:0]  m;
    logic signed [W-1:0]  u;
    logic signed [W2-1:0] r;
    m = t[W-1:0] * C_QINV;
    u = m;
    r = (t - u * C_QW) >>> W;
    if (r < 0) r = r + C_QW;
    return r[W-1:0];
  endfunction

  logic                 s1_valid_q, s2_valid_q, s3_valid_q;
  logic                 adv;
  logic [W-1:0]         s1_sum_q, s1_diff_q, s1_tw_q;
  logic                 s1_mode_q;
  logic signed [W2-1:0] s2_pa_q, s2_pb_q;
  logic [W-1:0]         s2_sum_q;
  logic                 s2_mode_q;
  logic [W-1:0]         s3_a_q, s3_b_q;

  logic signed [W:0]    ra, rb, sum_x, diff_x;
  logic [W-1:0]         s1_sum_d, s1_diff_d;
  logic signed [W2-1:0] s2_pa_d, s2_pb_d;
  logic [W-1:0]         s3_a_d, s3_b_d;

  // A full S3 that is not being drained stalls the whole pipe.
  assign adv          = !s3_valid_q || bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin
    ra     = reduce_in(bus.coeff_a_i);
    rb     = reduce_in(bus.coeff_b_i);
    sum_x  = ra + rb;
    if (sum_x >= C_QE) sum_x = sum_x - C_QE;
    diff_x = ra - rb;
    if (diff_x < 0) diff_x = diff_x + C_QE;
    s1_sum_d  = sum_x[W-1:0];
    s1_diff_d = diff_x[W-1:0];
    s2_pa_d   = $signed({{W{1'b0}}, s1_sum_q})  * $signed({{W{1'b0}}, s1_tw_q});
    s2_pb_d   = $signed({{W{1'b0}}, s1_diff_q}) * $signed({{W{1'b0}}, s1_tw_q});
    s3_b_d    = mont(s2_pb_q);
    s3_a_d    = s2_mode_q ? mont(s2_pa_q) : s2_sum_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_diff_q  <= '0;
      s1_tw_q    <= '0;
      s1_mode_q  <= 1'b0;
      s2_pa_q    <= '0;
      s2_pb_q    <= '0;
      s2_sum_q   <= '0;
      s2_mode_q  <= 1'b0;
      s3_a_q     <= '0;
      s3_b_q     <= '0;
    end else if (adv) begin
      s1_valid_q <= bus.in_valid;
      s1_sum_q   <= s1_sum_d;
      s1_diff_q  <= s1_diff_d;
      s1_tw_q    <= bus.twiddle_i;
      s1_mode_q  <= bus.mode_scale_i;
      s2_valid_q <= s1_valid_q;
      s2_pa_q    <= s2_pa_d;
      s2_pb_q    <= s2_pb_d;
      s2_sum_q   <= s1_sum_q;
      s2_mode_q  <= s1_mode_q;
      s3_valid_q <= s2_valid_q;
      s3_a_q     <= s3_a_d;
      s3_b_q     <= s3_b_d;
    end
  end

  assign bus.out_valid = s3_valid_q;
  assign bus.coeff_a_o = s3_a_q;
  assign bus.coeff_b_o = s3_b_q;
  assign busy_o        = s1_valid_q | s2_valid_q | s3_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_intt_butterfly.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_intt_butterfly : self-checking bench for intt_butterfly          |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_intt_butterfly;
  localparam int W    = 16;
  localparam int Q    = 3329;
  localparam int RINV = 169;  // 2^-16 mod 3329

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  always #5 clk = ~clk;

  intt_butterfly_if #(.W(W)) bus ();

  intt_butterfly #(.W(W), .Q(Q), .QINV(62209)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy_o(busy)
  );

  function automatic int modq(input int x);
    return ((x % Q) + Q) % Q;
  endfunction

  // Plain modular arithmetic: a' = a+b (optionally *zeta), b' = (a-b)*zeta, zeta = tw*R^-1.
  function automatic logic [31:0] model(input int a, input int b, input int tw, input bit m);
    int s, d, zeta, ao, bo;
    s    = modq(a + b);
    d    = modq(a - b);
    zeta = modq(tw * RINV);
    bo   = (d * zeta) % Q;
    ao   = m ? (s * zeta) % Q : s;
    return {16'(ao), 16'(bo)};
  endfunction

  function automatic int pick_coeff();
    case ($urandom_range(0, 5))
      0:       return -Q;
      1:       return 2 * Q - 1;
      2:       return Q - 1;
      default: return int'($urandom_range(0, 3 * Q - 1)) - Q;
    endcase
  endfunction

  task automatic rand_beat();
    bus.coeff_a_i    = 16'(pick_coeff());
    bus.coeff_b_i    = 16'(pick_coeff());
    bus.twiddle_i    = 16'($urandom_range(0, Q - 1));
    bus.mode_scale_i = 1'($urandom_range(0, 1));
  endtask

  task automatic tick();
    if (bus.in_valid && bus.in_ready)
      exp_q.push_back(model(bus.coeff_a_i, bus.coeff_b_i, bus.twiddle_i, bus.mode_scale_i));
    if (bus.out_valid && bus.out_ready)
      obs_q.push_back({bus.coeff_a_o, bus.coeff_b_o});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    rand_beat();
    repeat (2) begin @(posedge clk); #1; end
    bus.in_valid = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
    n_checks++; if ({bus.coeff_a_o, bus.coeff_b_o} !== 32'h0) $display("FAIL reset_data got %h want 0", {bus.coeff_a_o, bus.coeff_b_o}); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    int va[5] = '{100, 30, 3000, 128, -3329};
    int vb[5] = '{30, 100, 1000, 0, 6657};
    int vt[5] = '{2285, 2285, 2285, 512, 2285};
    bit vm[5] = '{0, 0, 0, 1, 0};
    int ea[5] = '{130, 130, 671, 1, 3328};
    int eb[5] = '{70, 3259, 2000, 1, 1};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.coeff_a_i = 16'(va[i]);
      bus.coeff_b_i = 16'(vb[i]);
      bus.twiddle_i = 16'(vt[i]);
      bus.mode_scale_i = vm[i];
      bus.in_valid = 1'b1;
      #1; tick();
      bus.in_valid = 1'b0;
      #1; tick();
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL vec%0d_early_valid got %0b want 0", i, bus.out_valid); else n_pass++;
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.coeff_a_o !== 16'(ea[i]) || bus.coeff_b_o !== 16'(eb[i]))
        $display("FAIL vec%0d got v=%0b a=%0d b=%0d want v=1 a=%0d b=%0d",
                 i, bus.out_valid, bus.coeff_a_o, bus.coeff_b_o, ea[i], eb[i]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int stalls = 0;
    bit stalled_prev = 0;
    bit acc;
    logic [31:0] held = '0;
    exp_q.delete(); obs_q.delete();
    rand_beat();
    for (int c = 0; c < 20; c++) begin
      bus.out_ready = !(c >= 4 && c <= 8);
      bus.in_valid  = (sent < 5);
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        stalls++;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready c=%0d got %0b want 0", c, bus.in_ready); else n_pass++;
        if (stalled_prev) begin
          n_checks++; if ({bus.coeff_a_o, bus.coeff_b_o} !== held) $display("FAIL bp_hold c=%0d got %h want %h", c, {bus.coeff_a_o, bus.coeff_b_o}, held); else n_pass++;
        end
        held = {bus.coeff_a_o, bus.coeff_b_o};
        stalled_prev = 1;
      end else stalled_prev = 0;
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) begin sent++; rand_beat(); end
    end
    bus.in_valid = 1'b0;
    n_checks++; if (stalls !== 5) $display("FAIL bp_stall_cycles got %0d want 5", stalls); else n_pass++;
    n_checks++; if (obs_q.size() !== 5) $display("FAIL bp_count got %0d want 5", obs_q.size()); else n_pass++;
    for (int i = 0; i < 5 && i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL bp_data%0d got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_random();
    bit pending = 0;
    bit acc;
    int errs = 0;
    exp_q.delete(); obs_q.delete();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!pending) begin
        bus.in_valid = ($urandom_range(0, 9) < 7);
        if (bus.in_valid) rand_beat();
        pending = bus.in_valid;
      end
      bus.out_ready = ($urandom_range(0, 9) < 7);
      #1;
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) pending = 0;
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL rand_drained_busy got %0b want 0", busy); else n_pass++;
    n_checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errs++;
        if (errs < 10) $display("FAIL rand_data%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end else n_pass++;
    end
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_beat();
      bus.in_valid = 1'b1;
      #1; tick();
    end
    bus.in_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL mid_busy_before got %0b want 1", busy); else n_pass++;
    rst_n = 1'b0;
    #1; tick();
    rst_n = 1'b1;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL mid_out_valid got %0b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy got %0b want 0", busy); else n_pass++;
    n_checks++; if ({bus.coeff_a_o, bus.coeff_b_o} !== 32'h0) $display("FAIL mid_data got %h want 0", {bus.coeff_a_o, bus.coeff_b_o}); else n_pass++;
    bus.coeff_a_i = 16'sd100;
    bus.coeff_b_i = 16'sd30;
    bus.twiddle_i = 16'sd2285;
    bus.mode_scale_i = 1'b0;
    bus.in_valid = 1'b1;
    #1; tick();
    bus.in_valid = 1'b0;
    #1; tick();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL mid_stale_valid got %0b want 0", bus.out_valid); else n_pass++;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.coeff_a_o !== 16'd130 || bus.coeff_b_o !== 16'd70)
      $display("FAIL mid_post_beat got v=%0b a=%0d b=%0d want v=1 a=130 b=70", bus.out_valid, bus.coeff_a_o, bus.coeff_b_o);
    else n_pass++;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.mode_scale_i = 1'b0;
    bus.coeff_a_i = '0;
    bus.coeff_b_i = '0;
    bus.twiddle_i = '0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
